// File: rtl/controller_pkg.sv
// Shared constants and the control-word type for the single-cycle instruction decoder.
package controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_FUNC   = 2'b10,
    ALU_UNUSED = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic is_supported_func(input logic [5:0] func);
    return (func == FN_ADD) || (func == FN_SUB) || (func == FN_AND) ||
           (func == FN_OR)  || (func == FN_SLT);
  endfunction

endpackage

// File: rtl/controller_decode.sv
// Combinational opcode/func decode into the next control word.
module controller_decode
  import controller_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output ctrl_t      ctrl
);

  // func is consulted only in the R-type arm so it cannot leak into other decodes.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = is_supported_func(func);
        ctrl.alu_op    = ALU_FUNC;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Registered main control unit: decodes opcode/func and presents the result one cycle later.
module controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] func,
  input  logic [5:0] opcode,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       branch,
  output logic [1:0] alu_op
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  controller_decode u_decode (
    .opcode (opcode),
    .func   (func),
    .ctrl   (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end

  // Outputs come straight from the control register, never from the inputs.
  always_comb begin
    RegDst   = ctrl_q.reg_dst;
    RegWrite = ctrl_q.reg_write;
    ALUSrc   = ctrl_q.alu_src;
    MemToReg = ctrl_q.mem_to_reg;
    MemRead  = ctrl_q.mem_read;
    MemWrite = ctrl_q.mem_write;
    branch   = ctrl_q.branch;
    alu_op   = ctrl_q.alu_op;
  end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed scenarios plus randomized traffic against a table model.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] func;
  logic [5:0] opcode;
  logic       RegDst, RegWrite, ALUSrc, MemToReg, MemRead, MemWrite, branch;
  logic [1:0] alu_op;

  int n_chk  = 0;
  int n_pass = 0;

  controller dut (
    .clk      (clk),
    .rst      (rst),
    .func     (func),
    .opcode   (opcode),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .ALUSrc   (ALUSrc),
    .MemToReg (MemToReg),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .branch   (branch),
    .alu_op   (alu_op)
  );

  always #5 clk = ~clk;

  // Control word order: RegDst RegWrite ALUSrc MemToReg MemRead MemWrite branch alu_op[1:0]
  function automatic logic [8:0] observed();
    return {RegDst, RegWrite, ALUSrc, MemToReg, MemRead, MemWrite, branch, alu_op};
  endfunction

  function automatic logic [8:0] model(input logic r, input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] ok_funcs [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    logic       ok = 1'b0;
    if (r) return 9'b0;
    case (op)
      6'd0: begin
        foreach (ok_funcs[i]) if (fn === ok_funcs[i]) ok = 1'b1;
        return {1'b1, ok, 5'b00000, 2'b10};
      end
      6'd35:   return 9'b0_1_1_1_1_0_0_00;
      6'd43:   return 9'b0_0_1_0_0_1_0_00;
      6'd4:    return 9'b0_0_0_0_0_0_1_01;
      default: return 9'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Apply inputs, clock once, then check outputs plus the exclusivity/no-X invariants.
  task automatic step(input string tag, input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic fn_x);
    logic [8:0] exp;
    logic [8:0] o;
    rst    = r;
    opcode = op;
    func   = fn_x ? 6'bx : fn;
    exp    = model(r, op, fn_x ? 6'b0 : fn);
    if (op == 6'd0 && fn_x) exp = 9'b0;
    @(posedge clk);
    #1;
    o = observed();
    chk(tag, o, exp);
    chk({tag, "_nox"}, {8'b0, $isunknown(o)}, 9'b0);
    chk({tag, "_excl"}, {7'b0, MemRead & MemWrite, RegWrite & MemWrite}, 9'b0);
  endtask

  initial begin
    logic [8:0] held;
    logic [5:0] op, fn;
    logic       r;
    logic [5:0] ops [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2};
    logic [5:0] fns [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};

    rst = 1'b1; opcode = 6'd35; func = 6'd0;
    // Scenario 1: reset holds everything low, lw decode one cycle after release
    step("rst0", 1'b1, 6'd35, 6'd0, 1'b0);
    step("rst1", 1'b1, 6'd35, 6'd0, 1'b0);
    step("lw_after_rst", 1'b0, 6'd35, 6'd0, 1'b0);

    // Scenario 2: supported R-type funcs
    step("r_add", 1'b0, 6'd0, 6'b100000, 1'b0);
    step("r_sub", 1'b0, 6'd0, 6'b100010, 1'b0);
    step("r_and", 1'b0, 6'd0, 6'b100100, 1'b0);
    step("r_or",  1'b0, 6'd0, 6'b100101, 1'b0);
    step("r_slt", 1'b0, 6'd0, 6'b101010, 1'b0);

    // Scenarios 3 and 4: func undriven for non-R-type opcodes
    step("lw_fx",  1'b0, 6'd35, 6'd0, 1'b1);
    step("sw_fx",  1'b0, 6'd43, 6'd0, 1'b1);
    step("beq_fx", 1'b0, 6'd4,  6'd0, 1'b1);

    // Scenario 5: unsupported opcode, then unsupported func
    step("op_j",   1'b0, 6'd2, 6'd0, 1'b0);
    step("r_bad",  1'b0, 6'd0, 6'd0, 1'b0);

    // Scenario 6: input change between edges must not show until the next edge
    step("lat_a", 1'b0, 6'd43, 6'd0, 1'b0);
    held = observed();
    opcode = 6'd35;
    #2;
    chk("lat_hold", observed(), held);
    @(posedge clk);
    #1;
    chk("lat_b", observed(), model(1'b0, 6'd35, 6'd0));

    // Mid-stream reset overrides decode, first decode after release uses that edge's inputs
    step("mid_rst", 1'b1, 6'd43, 6'd0, 1'b0);
    step("post_rst", 1'b0, 6'd4, 6'd0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 4)];
      fn = ($urandom_range(0, 2) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      r  = ($urandom_range(0, 19) == 0);
      step("rand", r, op, fn, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
